// File: rtl/tick_pwm_gen.sv
// Tick-driven PWM generator: Moore FSM counting time-base ticks through a
// HIGH phase of duty_q ticks and a LOW phase filling out per_q ticks.
module tick_pwm_gen #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         tick,
  input  logic [W-1:0] period,
  input  logic [W-1:0] duty,
  output logic         pwm,
  output logic         cycle_done,
  output logic         busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } state_e;

  localparam logic [W-1:0] One = {{(W-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] per_q, per_d;
  logic [W-1:0] duty_q, duty_d;
  logic         done_q, done_d;

  logic         start_ok;
  logic [W-1:0] duty_clamp;
  state_e       start_state;
  logic [W-1:0] cnt_inc;
  logic         cnt_last;

  assign start_ok    = enable && (period != '0);
  assign duty_clamp  = (duty > period) ? period : duty;
  assign start_state = (duty_clamp != '0) ? StHigh : StLow;
  assign cnt_inc     = cnt_q + One;
  assign cnt_last    = (cnt_q == (per_q - One));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          per_d   = period;
          duty_d  = duty_clamp;
          cnt_d   = '0;
          state_d = start_state;
        end
      end
      StHigh, StLow: begin
        // Dropping enable aborts the period even if a tick arrives this cycle.
        if (!enable) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_last) begin
            done_d = 1'b1;
            if (start_ok) begin
              per_d   = period;
              duty_d  = duty_clamp;
              cnt_d   = '0;
              state_d = start_state;
            end else begin
              state_d = StIdle;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_inc;
            if ((state_q == StHigh) && (cnt_inc == duty_q)) begin
              state_d = StLow;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      per_q   <= '0;
      duty_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
    end
  end

  assign pwm        = (state_q == StHigh);
  assign busy       = (state_q != StIdle);
  assign cycle_done = done_q;

endmodule

// File: tb/tb_tick_pwm_gen.sv
// Directed bench for tick_pwm_gen; expected waveforms are hand-derived per step.
module tb_tick_pwm_gen;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         enable;
  logic         tick;
  logic [W-1:0] period;
  logic [W-1:0] duty;
  logic         pwm;
  logic         cycle_done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  tick_pwm_gen #(.W(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .tick       (tick),
    .period     (period),
    .duty       (duty),
    .pwm        (pwm),
    .cycle_done (cycle_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive tick for one edge, then sample 1 time unit after that edge.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic p, input logic b, input logic d);
    chk({tag, ".pwm"}, pwm, p);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".done"}, cycle_done, d);
  endtask

  logic [7:0] exp_pwm4;
  logic [7:0] exp_done4;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    tick    = 1'b0;
    period  = '0;
    duty    = '0;
    cyc(1'b0);
    cyc(1'b1);
    chk3("reset", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cyc(1'b0);
    chk3("idle_after_reset", 1'b0, 1'b0, 1'b0);

    // 1: period 4, duty 1, tick every 3 clk -> 3 clk high, 9 low, done every 12.
    period = 8'd4;
    duty   = 8'd1;
    enable = 1'b1;
    cyc(1'b0);
    chk3("s1_start", 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      cyc((c % 3) == 0);
      chk3($sformatf("s1_c%0d", c), (c % 12) < 3, 1'b1, (c % 12) == 0);
    end

    enable = 1'b0;
    cyc(1'b0);
    chk3("s1_stop", 1'b0, 1'b0, 1'b0);

    // 2: duty 9 clamps to period 5; pwm never drops, done every 5 ticks.
    period = 8'd5;
    duty   = 8'd9;
    enable = 1'b1;
    cyc(1'b0);
    chk3("s2_start", 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      cyc(1'b1);
      chk3($sformatf("s2_c%0d", c), 1'b1, 1'b1, (c % 5) == 0);
    end

    enable = 1'b0;
    cyc(1'b0);
    chk3("s2_stop", 1'b0, 1'b0, 1'b0);

    // 3: duty 0, period 3, tick every 2 clk -> LOW only, done every 6 clk.
    period = 8'd3;
    duty   = 8'd0;
    enable = 1'b1;
    cyc(1'b0);
    chk3("s3_start", 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      cyc((c % 2) == 0);
      chk3($sformatf("s3_c%0d", c), 1'b0, 1'b1, (c % 6) == 0);
    end
    // period 0 seen at the next period end -> finish that period, then IDLE.
    period = 8'd0;
    for (int c = 13; c <= 22; c++) begin
      cyc((c % 2) == 0);
      chk3($sformatf("s3_c%0d", c), 1'b0, c < 18, c == 18);
    end

    // 4: period 4, duty 2 -> 3 mid-period; tick every clk.
    period    = 8'd4;
    duty      = 8'd2;
    exp_pwm4  = 8'b1011_1001;
    exp_done4 = 8'b1000_1000;
    cyc(1'b0);
    chk3("s4_start", 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      cyc(1'b1);
      if (c == 1) duty = 8'd3;
      chk3($sformatf("s4_c%0d", c), exp_pwm4[c-1], 1'b1, exp_done4[c-1]);
    end

    // 5: enable drops together with a tick while HIGH -> IDLE, no done.
    cyc(1'b1);
    chk3("s5_high", 1'b1, 1'b1, 1'b0);
    enable = 1'b0;
    cyc(1'b1);
    chk3("s5_abort", 1'b0, 1'b0, 1'b0);
    cyc(1'b1);
    chk3("s5_idle", 1'b0, 1'b0, 1'b0);

    // 6: reset pulse mid-LOW, then clean restart.
    period = 8'd4;
    duty   = 8'd1;
    enable = 1'b1;
    cyc(1'b0);
    chk3("s6_start", 1'b1, 1'b1, 1'b0);
    cyc(1'b1);
    chk3("s6_low1", 1'b0, 1'b1, 1'b0);
    cyc(1'b1);
    chk3("s6_low2", 1'b0, 1'b1, 1'b0);
    reset_n = 1'b0;
    cyc(1'b1);
    chk3("s6_reset", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cyc(1'b0);
    chk3("s6_restart", 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      cyc(1'b1);
      chk3($sformatf("s6_c%0d", c), c == 4, 1'b1, c == 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
